// File: rtl/data_mem.sv
// Shared multi-port data memory for the NRISC cores: clocked writes, combinational
// gated reads, whole array cleared by an asynchronous active-low reset.
module data_mem #(
    parameter int Ncores = 2,
    parameter int Lmem   = 8,
    parameter int TAM    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:TAM-1]    dataIN0,
    input  logic [0:TAM-1]    dataIN1,
    input  logic [0:TAM-1]    dataADDR0,
    input  logic [0:TAM-1]    dataADDR1,
    input  logic [0:Ncores-1] dataWrite,
    input  logic [0:Ncores-1] dataLoad,
    output logic [0:TAM-1]    dataOUT0,
    output logic [0:TAM-1]    dataOUT1
);

    localparam int DEPTH = 1 << Lmem;

    logic [Lmem-1:0] w_addr0;
    logic [Lmem-1:0] w_addr1;
    logic [0:TAM-1]  w_words [DEPTH];

    // Only the low Lmem address bits are decoded; higher bits alias.
    assign w_addr0 = dataADDR0[TAM-Lmem:TAM-1];
    assign w_addr1 = dataADDR1[TAM-Lmem:TAM-1];

    generate
        if (Lmem < TAM) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^{dataADDR0[0:TAM-Lmem-1], dataADDR1[0:TAM-Lmem-1]};
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            localparam logic [Lmem-1:0] WORD_ADDR = Lmem'(gi);
            logic [0:TAM-1] r_word;

            // Port 1 is checked first so it wins a same-address collision.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_word <= '0;
                end else if (dataWrite[1] && (w_addr1 == WORD_ADDR)) begin
                    r_word <= dataIN1;
                end else if (dataWrite[0] && (w_addr0 == WORD_ADDR)) begin
                    r_word <= dataIN0;
                end
            end

            assign w_words[gi] = r_word;
        end
    endgenerate

    assign dataOUT0 = dataLoad[0] ? w_words[w_addr0] : '0;
    assign dataOUT1 = dataLoad[1] ? w_words[w_addr1] : '0;

endmodule

// File: tb/tb_data_mem.sv
// Directed and randomized checks of data_mem through a scoreboard of expected port reads.
module tb_data_mem;

    logic        clk;
    logic        rst;
    logic [15:0] dataIN0;
    logic [15:0] dataIN1;
    logic [15:0] dataADDR0;
    logic [15:0] dataADDR1;
    logic [0:1]  dataWrite;
    logic [0:1]  dataLoad;
    logic [15:0] dataOUT0;
    logic [15:0] dataOUT1;

    data_mem #(.Ncores(2), .Lmem(8), .TAM(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .dataIN0   (dataIN0),
        .dataIN1   (dataIN1),
        .dataADDR0 (dataADDR0),
        .dataADDR1 (dataADDR1),
        .dataWrite (dataWrite),
        .dataLoad  (dataLoad),
        .dataOUT0  (dataOUT0),
        .dataOUT1  (dataOUT1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [15:0] exp;
        string       tag;
    } sb_t;

    sb_t         sb_q [$];
    logic [15:0] model_mem [256];
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
    endtask

    task automatic expect_out(input int port, input logic [15:0] exp, input string tag);
        sb_t e;
        e.port = port;
        e.exp  = exp;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t         e;
        logic [15:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = (e.port == 0) ? dataOUT0 : dataOUT1;
            n_assert++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s port%0d: observed %h expected %h", e.tag, e.port, obs, e.exp);
            end
        end
    endtask

    task automatic write2(input logic [0:1] wr, input logic [15:0] a0, input logic [15:0] d0,
                          input logic [15:0] a1, input logic [15:0] d1);
        dataWrite = wr;
        dataLoad  = 2'b00;
        dataADDR0 = a0;
        dataIN0   = d0;
        dataADDR1 = a1;
        dataIN1   = d1;
        step();
        if (wr[0]) model_mem[a0[7:0]] = d0;
        if (wr[1]) model_mem[a1[7:0]] = d1;
        dataWrite = 2'b00;
    endtask

    task automatic read2(input logic [0:1] ld, input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] e0, input logic [15:0] e1, input string tag);
        dataWrite = 2'b00;
        dataLoad  = ld;
        dataADDR0 = a0;
        dataADDR1 = a1;
        #1;
        expect_out(0, e0, tag);
        expect_out(1, e1, tag);
        drain();
        $display("read %s: ld=%b a0=%h a1=%h out0=%h out1=%h", tag, ld, a0, a1, dataOUT0, dataOUT1);
    endtask

    initial begin
        logic [15:0] ra0, ra1, rd0, rd1;
        logic [15:0] old1;

        rst       = 1'b0;
        dataIN0   = '0;
        dataIN1   = '0;
        dataADDR0 = '0;
        dataADDR1 = '0;
        dataWrite = 2'b00;
        dataLoad  = 2'b11;
        clear_model();

        step();
        read2(2'b11, 16'h0000, 16'h0000, 16'h0000, 16'h0000, "reset_state");
        @(negedge clk);
        rst = 1'b1;
        step();

        // Reset mid-operation after a write
        write2(2'b10, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000);
        read2(2'b11, 16'h0010, 16'h0010, 16'hBEEF, 16'hBEEF, "pre_reset");
        #1;
        rst = 1'b0;
        clear_model();
        read2(2'b11, 16'h0010, 16'h0010, 16'h0000, 16'h0000, "reset_async");
        // Writes while reset is held must be dropped
        dataWrite = 2'b10;
        dataADDR0 = 16'h0010;
        dataIN0   = 16'h5555;
        step();
        dataWrite = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        read2(2'b11, 16'h0010, 16'h0010, 16'h0000, 16'h0000, "reset_release");
        step();
        write2(2'b01, 16'h0000, 16'h0000, 16'h0010, 16'h4321);
        read2(2'b11, 16'h0010, 16'h0010, 16'h4321, 16'h4321, "first_write_after_reset");

        // Alternate write/load
        write2(2'b11, 16'h0005, 16'h1234, 16'h00A0, 16'hCAFE);
        read2(2'b11, 16'h0005, 16'h00A0, 16'h1234, 16'hCAFE, "alt_write_load");

        // Load gating
        read2(2'b00, 16'h0005, 16'h00A0, 16'h0000, 16'h0000, "gate_00");
        read2(2'b10, 16'h0005, 16'h00A0, 16'h1234, 16'h0000, "gate_10");
        read2(2'b01, 16'h0005, 16'h00A0, 16'h0000, 16'hCAFE, "gate_01");

        // Write collision: port 1 wins
        write2(2'b11, 16'h0033, 16'h1111, 16'h0033, 16'h2222);
        read2(2'b11, 16'h0033, 16'h0033, 16'h2222, 16'h2222, "collision");

        // Address aliasing
        write2(2'b10, 16'h0142, 16'h00AA, 16'h0000, 16'h0000);
        read2(2'b01, 16'h0000, 16'h0042, 16'h0000, 16'h00AA, "alias");
        read2(2'b10, 16'hFF42, 16'h0000, 16'h00AA, 16'h0000, "alias_hi");

        // Port 0 writes while port 1 reads the same word
        write2(2'b10, 16'h0001, 16'h0F0F, 16'h0000, 16'h0000);
        old1      = 16'h0F0F;
        dataWrite = 2'b10;
        dataADDR0 = 16'h0001;
        dataIN0   = 16'h7777;
        dataLoad  = 2'b01;
        dataADDR1 = 16'h0001;
        #1;
        expect_out(1, old1, "indep_before_edge");
        drain();
        step();
        model_mem[8'h01] = 16'h7777;
        dataWrite = 2'b00;
        expect_out(1, 16'h7777, "indep_after_edge");
        drain();
        $display("indep: port1 load 0x01 across port0 write, out1=%h", dataOUT1);

        // Same-port load and write in one cycle
        dataWrite = 2'b01;
        dataLoad  = 2'b01;
        dataADDR1 = 16'h00C3;
        dataIN1   = 16'h9ABC;
        #1;
        expect_out(1, 16'h0000, "same_port_before");
        drain();
        step();
        model_mem[8'hC3] = 16'h9ABC;
        dataWrite = 2'b00;
        expect_out(1, 16'h9ABC, "same_port_after");
        drain();

        // Randomized alternate write/load
        for (int it = 0; it < 1000; it++) begin
            ra0 = 16'($urandom);
            ra1 = 16'($urandom);
            rd0 = 16'($urandom);
            rd1 = 16'($urandom);
            if (it % 50 == 0) ra1 = {8'h00, ra0[7:0]};
            write2(2'b11, ra0, rd0, ra1, rd1);
            read2(2'b11, ra0, ra1, model_mem[ra0[7:0]], model_mem[ra1[7:0]], "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
